// File: rtl/rv32i_multicycle_controller_pkg.sv
// Shared encodings for the multicycle RV32I core: ALU op codes, datapath mux
// selects, controller states and instruction field constants.
package alu_types;
   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9
   } alu_control_t;
endpackage

package rv32i_defines;
   localparam logic [31:0] PC_START_ADDRESS = 32'h0000_0000;

   typedef enum logic [1:0] {
      SRC_A_PC     = 2'd0,
      SRC_A_PC_OLD = 2'd1,
      SRC_A_RA     = 2'd2,
      SRC_A_ZERO   = 2'd3
   } alu_src_a_t;

   typedef enum logic [1:0] {
      SRC_B_4   = 2'd0,
      SRC_B_IMM = 2'd1,
      SRC_B_RB  = 2'd2
   } alu_src_b_t;

   typedef enum logic [1:0] {
      RES_ALU      = 2'd0,
      RES_MEM_DATA = 2'd1,
      RES_ALU_LAST = 2'd2
   } result_src_t;

   typedef enum logic {
      ADR_PC       = 1'b0,
      ADR_ALU_LAST = 1'b1
   } mem_adr_src_t;

   typedef enum logic [2:0] {
      IMM_I = 3'd0,
      IMM_S = 3'd1,
      IMM_B = 3'd2,
      IMM_J = 3'd3,
      IMM_U = 3'd4
   } imm_src_t;

   typedef enum logic [3:0] {
      S_FETCH     = 4'h0,
      S_DECODE    = 4'h1,
      S_MEMADR    = 4'h2,
      S_MEMREAD   = 4'h3,
      S_MEMWB     = 4'h4,
      S_MEMWRITE  = 4'h5,
      S_EXECUTER  = 4'h6,
      S_EXECUTEI  = 4'h7,
      S_ALUWB     = 4'h8,
      S_JAL       = 4'h9,
      S_JALR      = 4'hA,
      S_JALR_JUMP = 4'hB,
      S_BRANCH    = 4'hC,
      S_LUI       = 4'hD,
      S_AUIPC     = 4'hE,
      S_ERROR     = 4'hF
   } statetype;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   // funct3 010/011 have no branch meaning in RV32I
   function automatic logic branch_f3_valid(input logic [2:0] f3);
      return f3[2:1] != 2'b01;
   endfunction
endpackage

// File: rtl/rv32i_multicycle_controller_alu_decoder.sv
// ALU operation decoder for R-type and I-type arithmetic instructions.
module rv32i_alu_decoder
   import alu_types::*;
   import rv32i_defines::*;
(
   input  logic [2:0]   funct3,
   input  logic         funct7_5,
   input  logic         is_rtype,
   output alu_control_t alu_control
);

   always_comb begin
      alu_control = ALU_ADD;
      case (funct3)
         // instr[30] is part of the immediate for addi, so only R-type may pick SUB
         F3_ADD:  alu_control = (is_rtype && funct7_5) ? ALU_SUB : ALU_ADD;
         F3_SLL:  alu_control = ALU_SLL;
         F3_SLT:  alu_control = ALU_SLT;
         F3_SLTU: alu_control = ALU_SLTU;
         F3_XOR:  alu_control = ALU_XOR;
         F3_SR:   alu_control = funct7_5 ? ALU_SRA : ALU_SRL;
         F3_OR:   alu_control = ALU_OR;
         F3_AND:  alu_control = ALU_AND;
         default: alu_control = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/rv32i_multicycle_controller.sv
// Main control FSM for the multicycle RV32I core: one Moore state register,
// all datapath selects and write enables decoded from state and instr.
module rv32i_multicycle_controller
   import alu_types::*;
   import rv32i_defines::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         ena,
   input  logic [31:0]  instr,
   input  logic         equal,
   input  logic         alu_lsb,
   output logic         pc_ena,
   output logic         ir_ena,
   output logic         mem_data_ena,
   output logic         mem_wr_ena,
   output logic         reg_write,
   output mem_adr_src_t mem_adr_src,
   output alu_src_a_t   alu_src_a,
   output alu_src_b_t   alu_src_b,
   output alu_control_t alu_control,
   output result_src_t  result_src,
   output imm_src_t     imm_src,
   output logic         illegal
);

   statetype     state, next_state;
   logic [6:0]   opcode;
   logic [2:0]   funct3;
   alu_control_t alu_dec_ctl;
   alu_control_t br_ctl;
   logic         br_taken;
   logic         pc_ena_raw, ir_ena_raw, mem_data_ena_raw, mem_wr_ena_raw, reg_write_raw;
   logic         wr_gate;
   logic         unused_instr_bits;

   assign opcode            = instr[6:0];
   assign funct3            = instr[14:12];
   assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

   rv32i_alu_decoder u_alu_dec (
      .funct3      (funct3),
      .funct7_5    (instr[30]),
      .is_rtype    (opcode == OP_RTYPE),
      .alu_control (alu_dec_ctl)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst)      state <= S_FETCH;
      else if (ena) state <= next_state;
   end

   always_comb begin
      br_ctl   = ALU_SUB;
      br_taken = equal;
      case (funct3)
         F3_BEQ:  begin br_ctl = ALU_SUB;  br_taken = equal;    end
         F3_BNE:  begin br_ctl = ALU_SUB;  br_taken = ~equal;   end
         F3_BLT:  begin br_ctl = ALU_SLT;  br_taken = alu_lsb;  end
         F3_BGE:  begin br_ctl = ALU_SLT;  br_taken = ~alu_lsb; end
         F3_BLTU: begin br_ctl = ALU_SLTU; br_taken = alu_lsb;  end
         F3_BGEU: begin br_ctl = ALU_SLTU; br_taken = ~alu_lsb; end
         default: begin br_ctl = ALU_SUB;  br_taken = 1'b0;     end
      endcase
   end

   always_comb begin
      imm_src = IMM_I;
      case (opcode)
         OP_STORE:         imm_src = IMM_S;
         OP_BRANCH:        imm_src = IMM_B;
         OP_JAL:           imm_src = IMM_J;
         OP_LUI, OP_AUIPC: imm_src = IMM_U;
         default:          imm_src = IMM_I;
      endcase
   end

   always_comb begin
      next_state       = state;
      pc_ena_raw       = 1'b0;
      ir_ena_raw       = 1'b0;
      mem_data_ena_raw = 1'b0;
      mem_wr_ena_raw   = 1'b0;
      reg_write_raw    = 1'b0;
      mem_adr_src      = ADR_PC;
      alu_src_a        = SRC_A_PC;
      alu_src_b        = SRC_B_4;
      alu_control      = ALU_ADD;
      result_src       = RES_ALU;
      illegal          = 1'b0;
      case (state)
         S_FETCH: begin
            ir_ena_raw = 1'b1;
            pc_ena_raw = 1'b1;
            next_state = S_DECODE;
         end
         // branch/jal target is computed here and parked in alu_last
         S_DECODE: begin
            alu_src_a = SRC_A_PC_OLD;
            alu_src_b = SRC_B_IMM;
            case (opcode)
               OP_LOAD, OP_STORE: next_state = S_MEMADR;
               OP_RTYPE:          next_state = S_EXECUTER;
               OP_ITYPE:          next_state = S_EXECUTEI;
               OP_JAL:            next_state = S_JAL;
               OP_JALR:           next_state = S_JALR;
               OP_BRANCH:         next_state = branch_f3_valid(funct3) ? S_BRANCH : S_ERROR;
               OP_LUI:            next_state = S_LUI;
               OP_AUIPC:          next_state = S_AUIPC;
               default:           next_state = S_ERROR;
            endcase
         end
         S_MEMADR: begin
            alu_src_a  = SRC_A_RA;
            alu_src_b  = SRC_B_IMM;
            next_state = opcode[5] ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            mem_adr_src      = ADR_ALU_LAST;
            mem_data_ena_raw = 1'b1;
            next_state       = S_MEMWB;
         end
         S_MEMWB: begin
            result_src    = RES_MEM_DATA;
            reg_write_raw = 1'b1;
            next_state    = S_FETCH;
         end
         S_MEMWRITE: begin
            mem_adr_src    = ADR_ALU_LAST;
            mem_wr_ena_raw = 1'b1;
            next_state     = S_FETCH;
         end
         S_EXECUTER: begin
            alu_src_a   = SRC_A_RA;
            alu_src_b   = SRC_B_RB;
            alu_control = alu_dec_ctl;
            next_state  = S_ALUWB;
         end
         S_EXECUTEI: begin
            alu_src_a   = SRC_A_RA;
            alu_src_b   = SRC_B_IMM;
            alu_control = alu_dec_ctl;
            next_state  = S_ALUWB;
         end
         S_ALUWB: begin
            result_src    = RES_ALU_LAST;
            reg_write_raw = 1'b1;
            next_state    = S_FETCH;
         end
         // PC takes the DECODE target while the ALU forms the link for ALUWB
         S_JAL: begin
            alu_src_a  = SRC_A_PC_OLD;
            result_src = RES_ALU_LAST;
            pc_ena_raw = 1'b1;
            next_state = S_ALUWB;
         end
         S_JALR: begin
            alu_src_a     = SRC_A_PC_OLD;
            reg_write_raw = 1'b1;
            next_state    = S_JALR_JUMP;
         end
         S_JALR_JUMP: begin
            alu_src_a  = SRC_A_RA;
            alu_src_b  = SRC_B_IMM;
            pc_ena_raw = 1'b1;
            next_state = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a   = SRC_A_RA;
            alu_src_b   = SRC_B_RB;
            alu_control = br_ctl;
            result_src  = RES_ALU_LAST;
            pc_ena_raw  = br_taken;
            next_state  = S_FETCH;
         end
         S_LUI: begin
            alu_src_a  = SRC_A_ZERO;
            alu_src_b  = SRC_B_IMM;
            next_state = S_ALUWB;
         end
         S_AUIPC: begin
            alu_src_a  = SRC_A_PC_OLD;
            alu_src_b  = SRC_B_IMM;
            next_state = S_ALUWB;
         end
         default: begin
            illegal    = 1'b1;
            next_state = S_ERROR;
         end
      endcase
   end

   // reset gates combinationally so a store in flight is killed the same cycle
   assign wr_gate      = ena & ~rst;
   assign pc_ena       = wr_gate & pc_ena_raw;
   assign ir_ena       = wr_gate & ir_ena_raw;
   assign mem_data_ena = wr_gate & mem_data_ena_raw;
   assign mem_wr_ena   = wr_gate & mem_wr_ena_raw;
   assign reg_write    = wr_gate & reg_write_raw;

endmodule

// File: tb/tb_rv32i_multicycle_controller.sv
// Randomized check of the multicycle controller against a per-instruction
// step-table model of the expected control outputs.
module tb_rv32i_multicycle_controller;
   import alu_types::*;
   import rv32i_defines::*;

   localparam int K_LW = 0, K_SW = 1, K_R = 2, K_I = 3, K_JAL = 4, K_JALR = 5,
                  K_BR = 6, K_LUI = 7, K_AUIPC = 8, K_BAD = 9;

   logic         clk = 1'b0;
   logic         rst, ena, equal, alu_lsb;
   logic [31:0]  instr;
   logic         pc_ena, ir_ena, mem_data_ena, mem_wr_ena, reg_write, illegal;
   mem_adr_src_t mem_adr_src;
   alu_src_a_t   alu_src_a;
   alu_src_b_t   alu_src_b;
   alu_control_t alu_control;
   result_src_t  result_src;
   imm_src_t     imm_src;
   logic [19:0]  obs;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   rv32i_multicycle_controller dut (
      .clk(clk), .rst(rst), .ena(ena), .instr(instr), .equal(equal), .alu_lsb(alu_lsb),
      .pc_ena(pc_ena), .ir_ena(ir_ena), .mem_data_ena(mem_data_ena), .mem_wr_ena(mem_wr_ena),
      .reg_write(reg_write), .mem_adr_src(mem_adr_src), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .alu_control(alu_control), .result_src(result_src),
      .imm_src(imm_src), .illegal(illegal)
   );

   assign obs = {pc_ena, ir_ena, mem_data_ena, mem_wr_ena, reg_write, illegal,
                 mem_adr_src, alu_src_a, alu_src_b, alu_control, result_src, imm_src};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%05h exp=%05h", tag, got, exp);
      end
   endtask

   function automatic int kind_of(input logic [31:0] ins);
      case (ins[6:0])
         OP_LOAD:   return K_LW;
         OP_STORE:  return K_SW;
         OP_RTYPE:  return K_R;
         OP_ITYPE:  return K_I;
         OP_JAL:    return K_JAL;
         OP_JALR:   return K_JALR;
         OP_BRANCH: return (ins[14:13] == 2'b01) ? K_BAD : K_BR;
         OP_LUI:    return K_LUI;
         OP_AUIPC:  return K_AUIPC;
         default:   return K_BAD;
      endcase
   endfunction

   // cycles per instruction; an illegal one is watched for a few error cycles
   function automatic int nsteps(input int k);
      case (k)
         K_LW:    return 5;
         K_BR:    return 3;
         K_BAD:   return 6;
         default: return 4;
      endcase
   endfunction

   function automatic logic [3:0] arith_op(input logic [31:0] ins, input logic rtype);
      case (ins[14:12])
         3'd0: return (rtype && ins[30]) ? ALU_SUB : ALU_ADD;
         3'd1: return ALU_SLL;
         3'd2: return ALU_SLT;
         3'd3: return ALU_SLTU;
         3'd4: return ALU_XOR;
         3'd5: return ins[30] ? ALU_SRA : ALU_SRL;
         3'd6: return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

   function automatic logic [19:0] model(input logic [31:0] ins, input int step,
                                         input logic eq, input logic lsb,
                                         input logic en, input logic rs);
      logic pc, ir, md, mw, rw, il, adr;
      logic [1:0] a, b, res;
      logic [3:0] alu;
      logic [2:0] imm;
      logic [2:0] f3;
      int k;
      k = kind_of(ins);
      f3 = ins[14:12];
      {pc, ir, md, mw, rw, il} = 6'b0;
      adr = ADR_PC; a = SRC_A_PC; b = SRC_B_4; alu = ALU_ADD; res = RES_ALU;
      case (ins[6:0])
         OP_STORE:         imm = IMM_S;
         OP_BRANCH:        imm = IMM_B;
         OP_JAL:           imm = IMM_J;
         OP_LUI, OP_AUIPC: imm = IMM_U;
         default:          imm = IMM_I;
      endcase
      if (rs) return {6'b0, adr, a, b, alu, res, imm};
      if (step == 0) begin
         ir = 1'b1; pc = 1'b1;
      end else if (step == 1) begin
         a = SRC_A_PC_OLD; b = SRC_B_IMM;
      end else begin
         case (k)
            K_LW: case (step)
               2: begin a = SRC_A_RA; b = SRC_B_IMM; end
               3: begin adr = ADR_ALU_LAST; md = 1'b1; end
               default: begin res = RES_MEM_DATA; rw = 1'b1; end
            endcase
            K_SW: if (step == 2) begin a = SRC_A_RA; b = SRC_B_IMM; end
                  else begin adr = ADR_ALU_LAST; mw = 1'b1; end
            K_R:  if (step == 2) begin a = SRC_A_RA; b = SRC_B_RB; alu = arith_op(ins, 1'b1); end
                  else begin res = RES_ALU_LAST; rw = 1'b1; end
            K_I:  if (step == 2) begin a = SRC_A_RA; b = SRC_B_IMM; alu = arith_op(ins, 1'b0); end
                  else begin res = RES_ALU_LAST; rw = 1'b1; end
            K_JAL: if (step == 2) begin a = SRC_A_PC_OLD; res = RES_ALU_LAST; pc = 1'b1; end
                   else begin res = RES_ALU_LAST; rw = 1'b1; end
            K_JALR: if (step == 2) begin a = SRC_A_PC_OLD; rw = 1'b1; end
                    else begin a = SRC_A_RA; b = SRC_B_IMM; pc = 1'b1; end
            K_BR: begin
               a = SRC_A_RA; b = SRC_B_RB; res = RES_ALU_LAST;
               alu = (f3[2:1] == 2'b00) ? ALU_SUB : (f3[1] ? ALU_SLTU : ALU_SLT);
               pc  = (f3[2] ? lsb : eq) ^ f3[0];
            end
            K_LUI: if (step == 2) begin a = SRC_A_ZERO; b = SRC_B_IMM; end
                   else begin res = RES_ALU_LAST; rw = 1'b1; end
            K_AUIPC: if (step == 2) begin a = SRC_A_PC_OLD; b = SRC_B_IMM; end
                     else begin res = RES_ALU_LAST; rw = 1'b1; end
            default: il = 1'b1;
         endcase
      end
      if (!en) {pc, ir, md, mw, rw} = 5'b0;
      return {pc, ir, md, mw, rw, il, adr, a, b, alu, res, imm};
   endfunction

   // One instruction from FETCH to completion; hold_step freezes 3 cycles,
   // rst_step pulses reset once at that step.
   task automatic run(input logic [31:0] ins, input int ena_pct, input int rst_pct,
                      input int hold_step, input int rst_step);
      int k, step, held;
      logic rs, did_rst;
      k = kind_of(ins);
      step = 0; held = 0; did_rst = 1'b0;
      instr = ins;
      while (step < nsteps(k)) begin
         ena = ($urandom_range(99) < ena_pct);
         if (step == hold_step && held < 3) begin ena = 1'b0; held++; end
         equal = 1'($urandom);
         alu_lsb = 1'($urandom);
         rs = ($urandom_range(99) < rst_pct);
         if (step == rst_step && !did_rst) begin rs = 1'b1; did_rst = 1'b1; end
         rst = rs;
         @(negedge clk);
         chk($sformatf("i%08h_s%0d", ins, step), {12'b0, obs},
             {12'b0, model(ins, step, equal, alu_lsb, ena, rs)});
         @(posedge clk); #1;
         if (rs) begin rst = 1'b0; step = 0; end
         else if (ena) step++;
      end
      if (k == K_BAD) begin
         rst = 1'b1;
         @(negedge clk);
         chk($sformatf("i%08h_errclr", ins), {12'b0, obs}, {12'b0, model(ins, 0, 1'b0, 1'b0, ena, 1'b1)});
         @(posedge clk); #1;
         rst = 1'b0;
      end
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] ins;
      int pick;
      logic [2:0] bf3 [6];
      bf3 = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
      ins = $urandom;
      pick = $urandom_range(15);
      case (pick)
         0, 1:    ins[6:0] = OP_LOAD;
         2:       ins[6:0] = OP_STORE;
         3, 4, 5: ins[6:0] = OP_RTYPE;
         6, 7, 8: ins[6:0] = OP_ITYPE;
         9:       ins[6:0] = OP_JAL;
         10:      ins[6:0] = OP_JALR;
         11, 12:  begin ins[6:0] = OP_BRANCH; ins[14:12] = bf3[$urandom_range(5)]; end
         13:      ins[6:0] = OP_LUI;
         14:      ins[6:0] = OP_AUIPC;
         default: begin
            if ($urandom_range(1) == 0) begin
               ins[6:0] = OP_BRANCH; ins[14:12] = {2'b01, 1'($urandom)};
            end else begin
               ins[6:0] = 7'h7F;
            end
         end
      endcase
      return ins;
   endfunction

   initial begin
      rst = 1'b1; ena = 1'b1; equal = 1'b0; alu_lsb = 1'b0; instr = 32'h0000_0013;
      @(negedge clk);
      chk("reset", {12'b0, obs}, {12'b0, model(instr, 0, 1'b0, 1'b0, 1'b1, 1'b1)});
      @(posedge clk); #1;
      rst = 1'b0;
      run(32'h0050_0093, 100, 0, -1, -1);   // addi x1,x0,5
      run(32'h0000_A103, 100, 0,  2, -1);   // lw with 3-cycle freeze in MEMADR
      run(32'h0020_A223, 100, 0, -1, -1);   // sw
      run(32'h0020_8463, 100, 0, -1, -1);   // beq
      run(32'h0020_8463, 100, 0, -1, -1);
      run(32'h0020_C463, 100, 0, -1, -1);   // blt
      run(32'h0020_C463, 100, 0, -1, -1);
      run(32'h0000_80E7, 100, 0, -1, -1);   // jalr x1,0(x1)
      run(32'h0000_006F, 100, 0, -1, -1);   // jal
      run(32'h0000_007F, 100, 0, -1, -1);   // illegal opcode
      run(32'h0020_A223, 100, 0, -1,  3);   // reset mid-MEMWRITE
      for (int n = 0; n < 300; n++)
         run(rand_instr(), 80, 2, -1, -1);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
